// File: rtl/fifo_load_sequencer_if.sv
// Bus bundle between fifo_load_sequencer and its memory port / FIFO bank.
// master: the sequencer; slave: memory, FIFO bank and control environment.
interface fifo_load_sequencer_if #(
  parameter int unsigned NUM_FIFOS  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
);
  // Control / status
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  busy;
  logic                  done;
  logic                  drain_valid;
  logic [31:0]           busy_cycles;

  // Memory read port
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_waitrequest;
  logic [WORD_WIDTH-1:0] mem_readdata;
  logic                  mem_readdatavalid;

  // FIFO bank
  logic [NUM_FIFOS-1:0]  fifo_wren;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic [NUM_FIFOS-1:0]  fifo_full;
  logic [NUM_FIFOS-1:0]  fifo_rden;
  logic [NUM_FIFOS-1:0]  fifo_empty;

  modport master (
    input  start, base_addr, mem_waitrequest, mem_readdata, mem_readdatavalid,
           fifo_full, fifo_empty,
    output busy, done, drain_valid, busy_cycles, mem_read, mem_addr,
           fifo_wren, fifo_wdata, fifo_rden
  );

  modport slave (
    output start, base_addr, mem_waitrequest, mem_readdata, mem_readdatavalid,
           fifo_full, fifo_empty,
    input  busy, done, drain_valid, busy_cycles, mem_read, mem_addr,
           fifo_wren, fifo_wdata, fifo_rden
  );
endinterface

// File: rtl/fifo_load_sequencer.sv
// Fills a bank of byte FIFOs one memory word per FIFO (unpacked LSB first),
// then drains all FIFOs in lockstep for DEPTH reads and pulses done.
// Optional feature macro: CTRL_PERF_CNT_EN enables the busy_cycles counter;
// without it busy_cycles is tied to zero.
module fifo_load_sequencer #(
  parameter int unsigned NUM_FIFOS  = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  fifo_load_sequencer_if.master bus
);

  localparam int unsigned CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FIDX_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UNPACK = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [FIDX_W-1:0] F_LAST   = FIDX_W'(NUM_FIFOS - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FIDX_W-1:0]     f_q, f_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
  logic [NUM_FIFOS-1:0]  wren_c;
  logic [NUM_FIFOS-1:0]  rden_c;
  logic                  busy_q, done_q, mem_read_q, drain_valid_q;

  // Next-state, datapath and FIFO strobe decode
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    wren_c  = '0;
    rden_c  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d  = bus.base_addr;
          addr_d  = bus.base_addr;
          f_d     = '0;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!bus.mem_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_readdatavalid) begin
          sreg_d  = bus.mem_readdata;
          cnt_d   = '0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        // A full FIFO stalls the shift so no byte is dropped
        if (!bus.fifo_full[f_q]) begin
          wren_c[f_q] = 1'b1;
          sreg_d      = sreg_q >> DATA_WIDTH;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            if (f_q == F_LAST) begin
              state_d = S_DRAIN;
            end else begin
              f_d     = f_q + FIDX_W'(1);
              addr_d  = base_q + ADDR_WIDTH'(f_q + FIDX_W'(1));
              state_d = S_REQ;
            end
          end
        end
      end
      S_DRAIN: begin
        // Lockstep pop only when every FIFO has data
        if (bus.fifo_empty == '0) begin
          rden_c = '1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      addr_q        <= '0;
      f_q           <= '0;
      cnt_q         <= '0;
      sreg_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_read_q    <= 1'b0;
      drain_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      addr_q        <= addr_d;
      f_q           <= f_d;
      cnt_q         <= cnt_d;
      sreg_q        <= sreg_d;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
      mem_read_q    <= (state_d == S_REQ);
      drain_valid_q <= |rden_c;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] busy_cycles_q;

  // Saturating count of busy cycles, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cycles_q <= '0;
    end else if (state_q == S_IDLE && bus.start) begin
      busy_cycles_q <= '0;
    end else if (state_q != S_IDLE && busy_cycles_q != 32'hFFFF_FFFF) begin
      busy_cycles_q <= busy_cycles_q + 32'd1;
    end
  end

  assign bus.busy_cycles = busy_cycles_q;
`else
  assign bus.busy_cycles = '0;
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_addr    = addr_q;
  assign bus.drain_valid = drain_valid_q;
  assign bus.fifo_wren   = wren_c;
  assign bus.fifo_rden   = rden_c;
  assign bus.fifo_wdata  = sreg_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_load_sequencer.sv
// Randomized bench for fifo_load_sequencer: emulates the memory port and the
// FIFO bank, and predicts every handshake from a transaction-level model.
module tb_fifo_load_sequencer;

  localparam int unsigned NF    = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 64;
  localparam int unsigned AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_load_sequencer_if #(
    .NUM_FIFOS(NF), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)
  ) bus ();

  fifo_load_sequencer #(
    .NUM_FIFOS(NF), .DEPTH(DEPTH), .DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Memory image, filled lazily with random words
  logic [WW-1:0] mem [logic [AW-1:0]];

  // Transaction-level model
  bit            in_op, req_open, unpacking, draining, done_due, prev_rd;
  bit            resp_pending;
  int unsigned   resp_cnt;
  logic [AW-1:0] resp_addr;
  logic [AW-1:0] base;
  int            fidx, wcnt, rd_cnt, req_cnt, busy_meas;
  int            fcnt [NF];

  // Stall knobs
  int unsigned p_wait = 0, p_full = 0, p_empty = 0, lat_max = 0;
  int          wr_force = 0, full_force = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    return mem[a];
  endfunction

  task automatic clear_model();
    in_op = 0; req_open = 0; unpacking = 0; draining = 0; done_due = 0;
    prev_rd = 0; resp_pending = 0; resp_cnt = 0; wcnt = 0; rd_cnt = 0;
    for (int i = 0; i < NF; i++) fcnt[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_readdata = '0;
    bus.fifo_full = '0;
    bus.fifo_empty = '1;
    @(posedge clk);
    #1;
    check_eq("rst_busy",        64'(bus.busy),        64'd0);
    check_eq("rst_done",        64'(bus.done),        64'd0);
    check_eq("rst_mem_read",    64'(bus.mem_read),    64'd0);
    check_eq("rst_mem_addr",    64'(bus.mem_addr),    64'd0);
    check_eq("rst_fifo_wren",   64'(bus.fifo_wren),   64'd0);
    check_eq("rst_fifo_rden",   64'(bus.fifo_rden),   64'd0);
    check_eq("rst_fifo_wdata",  64'(bus.fifo_wdata),  64'd0);
    check_eq("rst_drain_valid", 64'(bus.drain_valid), 64'd0);
    check_eq("rst_busy_cycles", 64'(bus.busy_cycles), 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample outputs, advance the model
  task automatic step(input logic start_i, input logic [AW-1:0] base_i);
    logic          wr, got_word, accept;
    logic [NF-1:0] full_v, empty_v, exp_wren, exp_rden;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    accept   = !in_op && start_i;
    got_word = 1'b0;
    bus.start     = start_i;
    bus.base_addr = base_i;
    wr = ($urandom_range(99) < p_wait);
    if (wr_force > 0 && req_open) begin
      wr = 1'b1;
      wr_force--;
    end
    bus.mem_waitrequest = wr;
    if (resp_pending && resp_cnt == 0) begin
      bus.mem_readdatavalid = 1'b1;
      bus.mem_readdata      = mem_word(resp_addr);
      resp_pending          = 0;
      got_word              = 1'b1;
    end else begin
      bus.mem_readdatavalid = 1'b0;
      bus.mem_readdata      = {$urandom, $urandom};
      if (resp_pending) resp_cnt--;
    end
    for (int i = 0; i < NF; i++) begin
      full_v[i]  = (fcnt[i] == DEPTH) || ($urandom_range(99) < p_full);
      empty_v[i] = (fcnt[i] == 0)     || ($urandom_range(99) < p_empty);
    end
    if (full_force > 0 && unpacking && fidx == 0 && wcnt == 3) begin
      full_v[0] = 1'b1;
      full_force--;
    end
    bus.fifo_full  = full_v;
    bus.fifo_empty = empty_v;
    #1;

    exp_wren = '0;
    if (unpacking && !full_v[fidx]) exp_wren[fidx] = 1'b1;
    exp_rden = (draining && empty_v == '0) ? '1 : '0;
    exp_addr = base + AW'(fidx);

    check_eq("busy",        64'(bus.busy),        64'(in_op));
    check_eq("done",        64'(bus.done),        64'(done_due));
    check_eq("drain_valid", 64'(bus.drain_valid), 64'(prev_rd));
    check_eq("mem_read",    64'(bus.mem_read),    64'(req_open));
    if (req_open) check_eq("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
    check_eq("fifo_wren",   64'(bus.fifo_wren),   64'(exp_wren));
    check_eq("fifo_rden",   64'(bus.fifo_rden),   64'(exp_rden));
    if (exp_wren != '0)
      check_eq("fifo_wdata", 64'(bus.fifo_wdata), 64'(DW'(mem_word(exp_addr) >> (DW * wcnt))));

    if (bus.busy) busy_meas++;
    prev_rd = |exp_rden;
    if (done_due) begin
      done_due = 0;
      in_op    = 0;
    end
    if (got_word) unpacking = 1;
    if (req_open && !wr) begin
      req_open     = 0;
      req_cnt++;
      resp_pending = 1;
      resp_addr    = exp_addr;
      resp_cnt     = $urandom_range(lat_max, 0);
    end
    if (exp_wren != '0) begin
      fcnt[fidx]++;
      wcnt++;
      if (wcnt == DEPTH) begin
        wcnt      = 0;
        unpacking = 0;
        if (fidx == NF - 1) draining = 1;
        else begin
          fidx++;
          req_open = 1;
        end
      end
    end
    if (exp_rden != '0) begin
      for (int i = 0; i < NF; i++) fcnt[i]--;
      rd_cnt++;
      if (rd_cnt == DEPTH) begin
        draining = 0;
        done_due = 1;
      end
    end
    if (accept) begin
      in_op = 1; base = base_i; fidx = 0; wcnt = 0; rd_cnt = 0;
      req_open = 1; req_cnt = 0; busy_meas = 0;
    end
  endtask

  // Full fill+drain; optionally pokes start with another base while unpacking
  task automatic run_txn(input logic [AW-1:0] b, input bit poke_start);
    int guard = 0;
    step(1'b1, b);
    while (in_op && guard < 2000) begin
      step(poke_start && unpacking && ($urandom_range(3) == 0), ~b);
      guard++;
    end
    check_eq("txn_completed", 64'(in_op), 64'd0);
    if (in_op) do_reset();
    step(1'b0, b);
    check_eq("req_count", 64'(req_cnt), 64'(NF));
    check_eq("busy_seen", 64'(busy_meas != 0), 64'd1);
`ifdef CTRL_PERF_CNT_EN
    check_eq("busy_cycles", 64'(bus.busy_cycles), 64'(busy_meas));
    step(1'b0, b);
    check_eq("busy_cycles_hold", 64'(bus.busy_cycles), 64'(busy_meas));
`else
    check_eq("busy_cycles", 64'(bus.busy_cycles), 64'd0);
`endif
  endtask

  initial begin
    int guard;
    clear_model();
    do_reset();

    // Directed: known words, 3-cycle waitrequest, 2-cycle full after 3rd byte
    mem[32'h10] = 64'h0807060504030201;
    mem[32'h11] = 64'h1817161514131211;
    wr_force   = 3;
    full_force = 2;
    run_txn(32'h10, 1'b0);
    check_eq("force_wait_used", 64'(wr_force), 64'd0);
    check_eq("force_full_used", 64'(full_force), 64'd0);

    // Address wrap with no stalls
    run_txn(32'hFFFF_FFFF, 1'b0);

    // Randomized stalls, latencies, bases; start poked mid-fill on odd runs
    for (int t = 0; t < 14; t++) begin
      p_wait  = $urandom_range(50);
      p_full  = $urandom_range(40);
      p_empty = $urandom_range(40);
      lat_max = $urandom_range(3);
      run_txn($urandom, t[0]);
    end

    // Reset while unpacking aborts the transaction
    p_wait = 0; p_full = 0; p_empty = 0; lat_max = 1;
    step(1'b1, 32'h40);
    guard = 0;
    while (!(unpacking && fcnt[0] >= 3) && guard < 500) begin
      step(1'b0, 32'h0);
      guard++;
    end
    check_eq("reached_unpack", 64'(unpacking), 64'd1);
    do_reset();
    step(1'b0, 32'h0);
    run_txn(32'h80, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
